mips_trace_buffer: RTL and testbench
====================================

MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the PC, instruction and ALU-result fields.
REQ-002 SHALL have parameter DEPTH, default 16: number of trace entries; must be a power of 2 and at least 2.
REQ-003 SHALL have parameter POST_TRIG, default 4: number of entries captured after the trigger entry; range 0..DEPTH-1.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 Port: globalclock  in  1  sole clock; all state updates on the rising edge.
REQ-006 Port: globalreset  in  1  synchronous active-high reset.
REQ-007 Port: cap_en  in  1  the current pc/instr/alu/branch set is a committed instruction to capture.
REQ-008 Port: pc_in  in  DATA_W  PC of the committed instruction.
REQ-009 Port: instr_in  in  DATA_W  instruction word.
REQ-010 Port: alu_in  in  DATA_W  ALU result.
REQ-011 Port: branch_in  in  1  branch taken.
REQ-012 Port: arm  in  1  single-cycle pulse that starts or restarts a capture.
REQ-013 Port: trig_mode  in  2  trigger select: 00 first capture; 01 pc_in==trig_pc; 10 branch_in; 11 alu_in==0.
REQ-014 Port: trig_pc  in  DATA_W  PC match value for mode 01.
REQ-015 Port: rd_en  in  1  pop the oldest entry; honoured only in DONE.
REQ-016 Port: rd_data  out  3*DATA_W+1  popped entry as {pc, instr, alu, branch}.
REQ-017 Port: rd_valid  out  1  rd_data valid for one cycle.
REQ-018 Port: count  out  clog2(DEPTH)+1  number of entries held.
REQ-019 Port: state  out  2  current state: 0 IDLE, 1 ARMED, 2 POST, 3 DONE.
REQ-020 Port: wrapped  out  1  at least one entry was overwritten since arm.

Function
REQ-021 FSM SHALL have states IDLE, ARMED, POST and DONE.
REQ-022 In any state, arm SHALL move the FSM to ARMED next cycle and clear wr_ptr, count, wrapped and the post counter; cap_en and rd_en in that cycle SHALL be ignored.
REQ-023 In ARMED and POST, when cap_en=1, the entry SHALL be written at wr_ptr and wr_ptr SHALL advance modulo DEPTH.
REQ-024 Count SHALL increment by 1 per write and saturate at DEPTH; a write while count==DEPTH SHALL overwrite the oldest entry and set wrapped.
REQ-025 In ARMED, a capture that matches trig_mode SHALL be stored as the trigger entry.
REQ-026 On that trigger capture, the FSM SHALL go to POST with the post counter loaded to POST_TRIG; if POST_TRIG==0 it SHALL go directly to DONE.
REQ-027 In POST, each capture SHALL decrement the post counter; the capture that brings it to 0 SHALL be stored and the FSM SHALL go to DONE.
REQ-028 Trigger conditions SHALL NOT be evaluated outside ARMED.
REQ-029 In DONE, cap_en SHALL be ignored.
REQ-030 On entry to DONE, rd_ptr SHALL equal (wr_ptr - count) mod DEPTH, the oldest entry.
REQ-031 In DONE with rd_en=1 and count>0, rd_data SHALL show the entry at rd_ptr with rd_valid=1 on the next cycle; rd_ptr SHALL advance and count SHALL decrement.
REQ-032 rd_en with count==0, or outside DONE, SHALL be ignored and rd_valid SHALL stay 0.
REQ-033 rd_data SHALL hold its last value when rd_valid=0.
REQ-034 In IDLE, captures and reads SHALL be ignored.

Reset
REQ-035 On globalreset=1 at the clock edge: state IDLE, count 0, wr_ptr 0, rd_ptr 0, post counter 0, wrapped 0, rd_valid 0, rd_data 0.
REQ-036 globalreset SHALL override arm, cap_en and rd_en in the same cycle, including mid-capture and mid-readout.
REQ-037 Trace memory contents need not be cleared by reset.

Verification (DEPTH=8, POST_TRIG=2, DATA_W=32)
REQ-038 Reset for 1 cycle -> state=0, count=0, rd_valid=0, rd_data=0, wrapped=0.
REQ-039 arm, mode 01, trig_pc=0x10, capture PC 0x00,0x04,... each cycle -> DONE after PC 0x18, count=7; 7 reads return PC 0x00..0x18 in order, rd_valid 1 cycle after each rd_en.
REQ-040 Mode 01, trig_pc=0x40, PCs 0x00..0x48 step 4 -> count=8, wrapped=1; reads return 0x2C..0x48.
REQ-041 Mode 10, branch_in=1 only on 3rd capture -> DONE after 5th capture, count=5; 3rd entry read has branch bit 1.
REQ-042 arm pulse while in POST -> state=1, count=0 next cycle; the old trigger is discarded.
REQ-043 rd_en in DONE with count=0, and globalreset during readout -> rd_valid stays 0 and state=0 the following cycle.

Source files
------------

// File: rtl/mips_trace_buffer.sv
// Instruction trace buffer: circular capture of committed {pc, instr, alu, branch},
// selectable trigger with post-trigger window, then oldest-first readout.
// Ports:
//   globalclock, globalreset            clock, synchronous active-high reset
//   cap_en, pc_in, instr_in, alu_in,
//   branch_in                           committed-instruction capture set
//   arm, trig_mode, trig_pc             capture start and trigger select
//   rd_en, rd_data, rd_valid            readout (DONE only), one entry per pop
//   count, state, wrapped               status
module mips_trace_buffer #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 4
) (
    input  logic                    globalclock,
    input  logic                    globalreset,
    input  logic                    cap_en,
    input  logic [DATA_W-1:0]       pc_in,
    input  logic [DATA_W-1:0]       instr_in,
    input  logic [DATA_W-1:0]       alu_in,
    input  logic                    branch_in,
    input  logic                    arm,
    input  logic [1:0]              trig_mode,
    input  logic [DATA_W-1:0]       trig_pc,
    input  logic                    rd_en,
    output logic [3*DATA_W:0]       rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic [1:0]              state,
    output logic                    wrapped
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = 3 * DATA_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   post_q;
    logic            wrapped_q;
    logic            cap, hit, rd_go, full;
    logic [EW-1:0]   mem [DEPTH];

    assign full = (count_q == CW'(DEPTH));

    always_comb begin
        state_d = state_q;
        hit     = 1'b0;
        unique case (trig_mode)
            2'b00: hit = 1'b1;
            2'b01: hit = (pc_in == trig_pc);
            2'b10: hit = branch_in;
            2'b11: hit = (alu_in == '0);
        endcase

        // arm takes priority over everything else in its cycle
        cap   = cap_en && !arm && (state_q == ARMED || state_q == POST);
        rd_go = rd_en && !arm && (state_q == DONE) && (count_q != '0);

        wr_d    = cap ? wr_q + AW'(1) : wr_q;
        count_d = count_q;
        if (cap && !full) begin
            count_d = count_q + CW'(1);
        end else if (rd_go) begin
            count_d = count_q - CW'(1);
        end

        if (arm) begin
            state_d = ARMED;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (cap && hit) begin
                        state_d = (POST_TRIG == 0) ? DONE : POST;
                    end
                end
                POST: begin
                    if (cap && post_q == AW'(1)) begin
                        state_d = DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge globalclock) begin
        if (globalreset) begin
            state_q   <= IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            post_q    <= '0;
            wrapped_q <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
        end else if (arm) begin
            state_q   <= ARMED;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            post_q    <= '0;
            wrapped_q <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
            rd_valid <= rd_go;
            if (cap && full) begin
                wrapped_q <= 1'b1;
            end
            if (state_q == ARMED && cap && hit) begin
                post_q <= AW'(POST_TRIG);
            end else if (state_q == POST && cap) begin
                post_q <= post_q - AW'(1);
            end
            // when full, count's low bits are zero so the oldest is wr_d itself
            if (state_q != DONE && state_d == DONE) begin
                rd_q <= wr_d - count_d[AW-1:0];
            end else if (rd_go) begin
                rd_q <= rd_q + AW'(1);
            end
            if (rd_go) begin
                rd_data <= mem[rd_q];
            end
        end
    end

    always_ff @(posedge globalclock) begin
        if (!globalreset && cap) begin
            mem[wr_q] <= {pc_in, instr_in, alu_in, branch_in};
        end
    end

    assign count   = count_q;
    assign state   = state_q;
    assign wrapped = wrapped_q;

endmodule

// File: tb/tb_mips_trace_buffer.sv
// Self-checking bench for mips_trace_buffer (DEPTH=8, POST_TRIG=2).
// Expected entries are queued as captures are driven and compared on readout.
module tb_mips_trace_buffer;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int PT    = 2;
    localparam int EW    = 3 * DW + 1;

    logic            globalclock = 1'b0;
    logic            globalreset;
    logic            cap_en;
    logic [DW-1:0]   pc_in, instr_in, alu_in, trig_pc;
    logic            branch_in;
    logic            arm;
    logic [1:0]      trig_mode;
    logic            rd_en;
    logic [EW-1:0]   rd_data;
    logic            rd_valid;
    logic [3:0]      count;
    logic [1:0]      state;
    logic            wrapped;

    logic [EW-1:0]   sb [$];
    logic [EW-1:0]   exp_e;
    logic [EW-1:0]   last;
    int              checks   = 0;
    int              failures = 0;

    always #5 globalclock = ~globalclock;

    mips_trace_buffer #(
        .DATA_W    (DW),
        .DEPTH     (DEPTH),
        .POST_TRIG (PT)
    ) dut (
        .globalclock (globalclock),
        .globalreset (globalreset),
        .cap_en      (cap_en),
        .pc_in       (pc_in),
        .instr_in    (instr_in),
        .alu_in      (alu_in),
        .branch_in   (branch_in),
        .arm         (arm),
        .trig_mode   (trig_mode),
        .trig_pc     (trig_pc),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .count       (count),
        .state       (state),
        .wrapped     (wrapped)
    );

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge globalclock);
        #1;
    endtask

    function automatic logic [EW-1:0] ent(input logic [DW-1:0] pc,
                                          input logic br,
                                          input logic [DW-1:0] alu);
        return {pc, pc ^ 32'hA5A5_0000, alu, br};
    endfunction

    task automatic do_arm(input logic [1:0] mode, input logic [DW-1:0] tpc);
        arm       = 1'b1;
        trig_mode = mode;
        trig_pc   = tpc;
        tick();
        arm = 1'b0;
        sb.delete();
        chk("arm_state", state, 2'd1);
        chk("arm_count", count, 0);
        chk("arm_wrapped", wrapped, 0);
    endtask

    task automatic cap(input logic [DW-1:0] pc, input logic br,
                       input logic [DW-1:0] alu, input bit push);
        cap_en    = 1'b1;
        pc_in     = pc;
        instr_in  = pc ^ 32'hA5A5_0000;
        alu_in    = alu;
        branch_in = br;
        if (push) begin
            sb.push_back(ent(pc, br, alu));
            if (sb.size() > DEPTH) void'(sb.pop_front());
        end
        tick();
        cap_en    = 1'b0;
        branch_in = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            tick();
            rd_en = 1'b0;
            exp_e = sb.pop_front();
            chk({tag, "_valid"}, rd_valid, 1);
            chk({tag, "_data"}, rd_data, exp_e);
            last = exp_e;
        end
        chk({tag, "_empty"}, count, 0);
        tick();
        chk({tag, "_idle_valid"}, rd_valid, 0);
        chk({tag, "_hold"}, rd_data, last);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit");
        $fatal(1);
    end

    initial begin
        globalreset = 1'b1;
        cap_en = 0; pc_in = 0; instr_in = 0; alu_in = 0; branch_in = 0;
        arm = 0; trig_mode = 0; trig_pc = 0; rd_en = 0;
        tick();
        globalreset = 1'b0;
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_wrapped", wrapped, 0);

        // IDLE ignores captures and reads
        cap(32'h300, 1'b0, 32'h1, 1'b0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("idle_count", count, 0);
        chk("idle_valid", rd_valid, 0);
        chk("idle_state", state, 0);

        // PC match trigger, no wrap
        do_arm(2'b01, 32'h10);
        for (int i = 0; i < 7; i++) begin
            cap(32'(4 * i), 1'b0, 32'(4 * i + 1), 1'b1);
            if (i == 4) chk("pc_post", state, 2'd2);
        end
        chk("pc_done", state, 2'd3);
        chk("pc_count", count, 7);
        chk("pc_wrapped", wrapped, 0);
        cap(32'h100, 1'b0, 32'h1, 1'b0);
        chk("done_ignore_cap", count, 7);
        drain("pc");

        // PC match with wrap-around
        do_arm(2'b01, 32'h40);
        for (int i = 0; i < 19; i++) begin
            cap(32'(4 * i), 1'b0, 32'(4 * i + 1), 1'b1);
        end
        chk("wrap_done", state, 2'd3);
        chk("wrap_count", count, 8);
        chk("wrap_flag", wrapped, 1);
        chk("wrap_oldest", sb[0][EW-1 -: DW], 32'h2C);
        drain("wrap");

        // branch trigger on 3rd capture
        do_arm(2'b10, 32'h0);
        for (int i = 0; i < 5; i++) begin
            cap(32'h400 + 32'(4 * i), i == 2, 32'h7, 1'b1);
            if (i == 2) chk("br_post", state, 2'd2);
        end
        chk("br_done", state, 2'd3);
        chk("br_count", count, 5);
        chk("br_wrapped", wrapped, 0);
        drain("br");

        // zero-ALU trigger on 2nd capture
        do_arm(2'b11, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cap(32'h500 + 32'(4 * i), 1'b0, (i == 1) ? 32'h0 : 32'h9, 1'b1);
        end
        chk("alu_done", state, 2'd3);
        chk("alu_count", count, 4);
        drain("alu");

        // re-arm during POST discards the old trigger; capture in arm cycle ignored
        do_arm(2'b00, 32'h0);
        cap(32'h600, 1'b0, 32'h1, 1'b1);
        chk("rearm_post", state, 2'd2);
        arm    = 1'b1;
        cap_en = 1'b1;
        pc_in  = 32'h604;
        tick();
        arm    = 1'b0;
        cap_en = 1'b0;
        sb.delete();
        chk("rearm_state", state, 2'd1);
        chk("rearm_count", count, 0);
        for (int i = 0; i < 3; i++) begin
            cap(32'h700 + 32'(4 * i), 1'b0, 32'h3, 1'b1);
        end
        chk("rearm_done", state, 2'd3);
        chk("rearm_cnt3", count, 3);
        drain("rearm");

        // read with empty buffer in DONE
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("empty_rd_valid", rd_valid, 0);
        chk("empty_rd_state", state, 2'd3);
        chk("empty_rd_count", count, 0);

        // reset in the middle of readout
        do_arm(2'b00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cap(32'h800 + 32'(4 * i), 1'b0, 32'h5, 1'b1);
        end
        rd_en = 1'b1;
        tick();
        exp_e = sb.pop_front();
        chk("mid_valid", rd_valid, 1);
        chk("mid_data", rd_data, exp_e);
        globalreset = 1'b1;
        tick();
        globalreset = 1'b0;
        rd_en = 1'b0;
        chk("mid_rst_valid", rd_valid, 0);
        chk("mid_rst_state", state, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_data", rd_data, 0);
        chk("mid_rst_wrapped", wrapped, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
